// File: rtl/pulsegen_pkg.sv
// Shared types and helpers for the multi-channel pulse generator.
//   state_t      : per-channel run state (IDLE, RUN)
//   calc_max     : converts a period in seconds to a compare value (clocks-1)
//   DEF_CNT_W    : default counter/period width
//   DEF_CLK_FREQ : default clock frequency in Hz
package pulsegen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_CNT_W    = 32;
  localparam int unsigned DEF_CLK_FREQ = 100_000_000;

  // Compare value for a pulse every period_s seconds (period = value+1 clocks).
  function automatic int calc_max(real period_s, int clk_freq);
    return $rtoi(period_s * clk_freq) - 1;
  endfunction

endpackage

// File: rtl/pulsegen_channel.sv
// One pulse-generator channel: state, counter, period and mode registers.
//   clk, reset          : clock, async active-high reset
//   wr                  : load period_in/oneshot_in at this edge
//   period_in           : compare value P (pulse every P+1 clocks)
//   oneshot_in          : 1 = one-shot, 0 = periodic
//   start, stop         : start/retrigger and stop strobes (stop wins)
//   pulse               : high while RUN and cnt >= period
//   active              : channel is in RUN
module pulsegen_channel
  import pulsegen_pkg::*;
#(
  parameter int unsigned      CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF_MAX = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [CNT_W-1:0] period_in,
  input  logic             oneshot_in,
  input  logic             start,
  input  logic             stop,
  output logic             pulse,
  output logic             active
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic             oneshot;

  // >= rather than == so a period shrunk below cnt fires next cycle instead of wrapping.
  assign pulse  = (state == RUN) && (cnt >= period);
  assign active = (state == RUN);

  // Channel state, counter and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= DEF_MAX;
      oneshot <= 1'b0;
    end else begin
      if (wr) begin
        period  <= period_in;
        oneshot <= oneshot_in;
      end

      if (stop) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (start) begin
        state <= RUN;
        cnt   <= '0;
      end else if (state == RUN) begin
        if (pulse) begin
          cnt <= '0;
          if (oneshot) state <= IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pulsegen_multi.sv
// Multi-channel runtime-programmable pulse generator.
//   clk, reset   : clock, async active-high reset
//   wr_en        : write strobe for period/mode of channel wr_ch
//   wr_ch        : channel index (writes to wr_ch >= NUM_CH are dropped)
//   wr_period    : new compare value P (pulse every P+1 clocks)
//   wr_oneshot   : 1 = one-shot, 0 = periodic
//   start, stop  : per-channel start/retrigger and stop strobes
//   pulse        : per-channel one-cycle pulse
//   active       : per-channel RUN indication
module pulsegen_multi
  import pulsegen_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned CLK_FREQ       = DEF_CLK_FREQ,
  parameter real         DEFAULT_PERIOD = 0.015,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_period,
  input  logic              wr_oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] active
);

  localparam logic [CNT_W-1:0] DEF_MAX = CNT_W'(calc_max(DEFAULT_PERIOD, int'(CLK_FREQ)));

  logic wr_ok_c;

  // Extra MSB keeps the range check meaningful when NUM_CH is a power of two.
  assign wr_ok_c = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel_c;

    assign wr_sel_c = wr_ok_c && (wr_ch == CH_W'(i));

    pulsegen_channel #(
      .CNT_W   (CNT_W),
      .DEF_MAX (DEF_MAX)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr         (wr_sel_c),
      .period_in  (wr_period),
      .oneshot_in (wr_oneshot),
      .start      (start[i]),
      .stop       (stop[i]),
      .pulse      (pulse[i]),
      .active     (active[i])
    );
  end

endmodule

// File: tb/tb_pulsegen_multi.sv
module tb_pulsegen_multi;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CH_W   = 3;
  localparam int          DEFP   = 9;   // $rtoi(0.01*1000)-1

  typedef struct {
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] a;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_period;
  logic              wr_oneshot;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] active;

  exp_t  sb[$];
  int    checks = 0;
  int    passed = 0;
  int    cyc    = 0;
  string tname  = "none";

  pulsegen_multi #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .CLK_FREQ       (1000),
    .DEFAULT_PERIOD (0.01)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_period  (wr_period),
    .wr_oneshot (wr_oneshot),
    .start      (start),
    .stop       (stop),
    .pulse      (pulse),
    .active     (active)
  );

  always #5 clk = ~clk;

  // Periodic pulse expected r cycles after the start edge, for compare value p.
  function automatic logic exp_per(int r, int p);
    return (r >= 0) && ((r % (p + 1)) == p);
  endfunction

  function automatic void push(logic [NUM_CH-1:0] p, logic [NUM_CH-1:0] a);
    exp_t e;
    e.p = p;
    e.a = a;
    sb.push_back(e);
  endfunction

  // Advance one clock, release strobes, compare against the next scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    start = '0;
    stop  = '0;
    wr_en = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard_empty cyc=%0d", tname, cyc);
    end else begin
      e = sb.pop_front();
      if (pulse !== e.p)
        $display("FAIL %s pulse cyc=%0d got=%b want=%b", tname, cyc, pulse, e.p);
      else if (active !== e.a)
        $display("FAIL %s active cyc=%0d got=%b want=%b", tname, cyc, active, e.a);
      else
        passed++;
    end
  endtask

  task automatic write(int ch, int p, logic os);
    wr_en      = 1'b1;
    wr_ch      = CH_W'(ch);
    wr_period  = CNT_W'(p);
    wr_oneshot = os;
  endtask

  task automatic idle_all();
    stop = '1;
    push('0, '0);
    tick();
  endtask

  task automatic test_reset();
    tname = "reset";
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pulse !== '0 || active !== '0)
      $display("FAIL reset_state got pulse=%b active=%b want 0/0", pulse, active);
    else
      passed++;
    reset = 1'b0;
    for (int r = 0; r < 4; r++) push('0, '0);
    repeat (4) tick();
  endtask

  task automatic test_default();
    tname = "default_period";
    start = 5'b00001;
    for (int r = 0; r < 30; r++) push(exp_per(r, DEFP) ? 5'b00001 : 5'b0, 5'b00001);
    repeat (30) tick();
    idle_all();
  endtask

  task automatic test_oneshot();
    tname = "oneshot";
    write(1, 3, 1'b1);
    push('0, '0);
    tick();
    start = 5'b00010;
    for (int r = 0; r < 50; r++)
      push((r == 3) ? 5'b00010 : 5'b0, (r <= 3) ? 5'b00010 : 5'b0);
    repeat (50) tick();
  endtask

  task automatic test_retrigger();
    tname = "retrigger";
    write(2, 9, 1'b0);
    push('0, '0);
    tick();
    start = 5'b00100;
    for (int r = 0; r < 15; r++) push(exp_per(r, 9) ? 5'b00100 : 5'b0, 5'b00100);
    repeat (15) tick();
    start = 5'b00100;
    for (int r = 0; r < 12; r++) push(exp_per(r, 9) ? 5'b00100 : 5'b0, 5'b00100);
    repeat (12) tick();
    tname = "start_stop_same";
    start = 5'b00100;
    stop  = 5'b00100;
    for (int r = 0; r < 12; r++) push('0, '0);
    repeat (12) tick();
  endtask

  task automatic test_shrink();
    tname = "shrink";
    write(0, 100, 1'b0);
    push('0, '0);
    tick();
    start = 5'b00001;
    for (int r = 0; r < 51; r++) push('0, 5'b00001);
    repeat (51) tick();
    write(0, 20, 1'b0);
    for (int r = 51; r < 72; r++) push(((r - 51) % 21 == 0) ? 5'b00001 : 5'b0, 5'b00001);
    repeat (21) tick();
    tname = "bad_wr_ch";
    write(5, 0, 1'b1);
    push(5'b00001, 5'b00001);
    tick();
    write(7, 0, 1'b1);
    for (int r = 73; r < 100; r++) push(((r - 51) % 21 == 0) ? 5'b00001 : 5'b0, 5'b00001);
    repeat (27) tick();
    idle_all();
  endtask

  task automatic test_edge();
    logic [NUM_CH-1:0] p;
    tname = "p0_periodic";
    write(3, 0, 1'b0);
    push('0, '0);
    tick();
    start = 5'b01000;
    for (int r = 0; r < 8; r++) push(5'b01000, 5'b01000);
    repeat (8) tick();
    idle_all();
    tname = "p0_oneshot";
    write(3, 0, 1'b1);
    push('0, '0);
    tick();
    start = 5'b01000;
    push(5'b01000, 5'b01000);
    for (int r = 1; r < 7; r++) push('0, '0);
    repeat (7) tick();
    tname = "independence";
    write(0, 2, 1'b0);
    push('0, '0);
    tick();
    write(3, 4, 1'b0);
    push('0, '0);
    tick();
    write(4, 1, 1'b0);
    start = 5'b11001;
    for (int r = 0; r < 12; r++) begin
      p    = '0;
      p[0] = exp_per(r, 2);
      p[3] = exp_per(r, 4);
      p[4] = exp_per(r, 1);
      push(p, 5'b11001);
    end
    repeat (12) tick();
    idle_all();
  endtask

  task automatic test_async_reset();
    logic [NUM_CH-1:0] p;
    tname = "pre_reset";
    start = 5'b01001;
    for (int r = 0; r < 3; r++) begin
      p    = '0;
      p[0] = exp_per(r, 2);
      p[3] = exp_per(r, 4);
      push(p, 5'b01001);
    end
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pulse !== '0 || active !== '0)
      $display("FAIL async_reset_drop got pulse=%b active=%b want 0/0", pulse, active);
    else
      passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (pulse !== '0 || active !== '0)
      $display("FAIL reset_release got pulse=%b active=%b want 0/0", pulse, active);
    else
      passed++;
    tname = "post_reset_default";
    start = 5'b00011;
    for (int r = 0; r < 22; r++) push(exp_per(r, DEFP) ? 5'b00011 : 5'b0, 5'b00011);
    repeat (22) tick();
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_ch      = '0;
    wr_period  = '0;
    wr_oneshot = 1'b0;
    start      = '0;
    stop       = '0;
    test_reset();
    test_default();
    test_oneshot();
    test_retrigger();
    test_shrink();
    test_edge();
    test_async_reset();
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
